// File: rtl/apb_master_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | apb_master_arbiter: two-requester round-robin APB master with timeout |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module apb_master_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 16
) (
  input  logic                  PCLK,
  input  logic                  PRESET,
  input  logic                  req0_valid,
  input  logic                  req0_write,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  output logic                  req0_grant,
  output logic                  req0_done,
  output logic [DATA_WIDTH-1:0] req0_rdata,
  output logic                  req0_err,
  input  logic                  req1_valid,
  input  logic                  req1_write,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  req1_grant,
  output logic                  req1_done,
  output logic [DATA_WIDTH-1:0] req1_rdata,
  output logic                  req1_err,
  output logic                  PSEL,
  output logic                  PENABLE,
  output logic                  PWRITE,
  output logic [ADDR_WIDTH-1:0] PADDR,
  output logic [DATA_WIDTH-1:0] PWDATA,
  input  logic [DATA_WIDTH-1:0] PRDATA,
  input  logic                  PREADY,
  input  logic                  PSLVERR
);

  localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_ACCESS = 2'd2
  } state_t;

  state_t                r_state, w_state_nxt;
  logic                  r_owner, w_owner_nxt;
  logic                  r_last_grant, w_last_nxt;
  logic [CW-1:0]         r_wait_cnt, w_wait_nxt;
  logic                  w_win;
  logic                  w_psel, w_penable, w_pwrite;
  logic [ADDR_WIDTH-1:0] w_paddr;
  logic [DATA_WIDTH-1:0] w_pwdata;
  logic [1:0]            w_grant, w_done, w_err;
  logic [DATA_WIDTH-1:0] w_rdata0, w_rdata1;

  // Contention goes to whoever was not served last; a lone request always wins.
  assign w_win = (req0_valid && req1_valid) ? ~r_last_grant : req1_valid;

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_grant;
    w_wait_nxt  = r_wait_cnt;
    w_psel      = PSEL;
    w_penable   = PENABLE;
    w_pwrite    = PWRITE;
    w_paddr     = PADDR;
    w_pwdata    = PWDATA;
    w_grant     = 2'b00;
    w_done      = 2'b00;
    w_err       = 2'b00;
    w_rdata0    = req0_rdata;
    w_rdata1    = req1_rdata;

    unique case (r_state)
      S_IDLE: begin
        w_psel    = 1'b0;
        w_penable = 1'b0;
        if (req0_valid || req1_valid) begin
          w_owner_nxt    = w_win;
          w_last_nxt     = w_win;
          w_pwrite       = w_win ? req1_write : req0_write;
          w_paddr        = w_win ? req1_addr  : req0_addr;
          w_pwdata       = w_win ? req1_wdata : req0_wdata;
          w_grant[w_win] = 1'b1;
          w_psel         = 1'b1;
          w_state_nxt    = S_SETUP;
        end
      end

      S_SETUP: begin
        w_penable   = 1'b1;
        w_wait_nxt  = '0;
        w_state_nxt = S_ACCESS;
      end

      S_ACCESS: begin
        if (PREADY) begin
          w_psel           = 1'b0;
          w_penable        = 1'b0;
          w_done[r_owner]  = 1'b1;
          w_err[r_owner]   = PSLVERR;
          w_state_nxt      = S_IDLE;
          if (!PWRITE) begin
            if (r_owner) w_rdata1 = PRDATA;
            else         w_rdata0 = PRDATA;
          end
        end else if ((TIMEOUT != 0) && (r_wait_cnt == CW'(TIMEOUT))) begin
          // Abort leaves rdata untouched; only the error flag reports it.
          w_psel          = 1'b0;
          w_penable       = 1'b0;
          w_done[r_owner] = 1'b1;
          w_err[r_owner]  = 1'b1;
          w_state_nxt     = S_IDLE;
        end else begin
          w_wait_nxt = r_wait_cnt + CW'(1);
        end
      end

      default: begin
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_last_grant <= 1'b1;
      r_wait_cnt   <= '0;
      PSEL         <= 1'b0;
      PENABLE      <= 1'b0;
      PWRITE       <= 1'b0;
      PADDR        <= '0;
      PWDATA       <= '0;
      req0_grant   <= 1'b0;
      req1_grant   <= 1'b0;
      req0_done    <= 1'b0;
      req1_done    <= 1'b0;
      req0_err     <= 1'b0;
      req1_err     <= 1'b0;
      req0_rdata   <= '0;
      req1_rdata   <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_owner      <= w_owner_nxt;
      r_last_grant <= w_last_nxt;
      r_wait_cnt   <= w_wait_nxt;
      PSEL         <= w_psel;
      PENABLE      <= w_penable;
      PWRITE       <= w_pwrite;
      PADDR        <= w_paddr;
      PWDATA       <= w_pwdata;
      req0_grant   <= w_grant[0];
      req1_grant   <= w_grant[1];
      req0_done    <= w_done[0];
      req1_done    <= w_done[1];
      req0_err     <= w_err[0];
      req1_err     <= w_err[1];
      req0_rdata   <= w_rdata0;
      req1_rdata   <= w_rdata1;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_apb_master_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_apb_master_arbiter: bench for the two-requester APB master         |
// | Revision: 1.0                                                         |
// +-----------------------------------------------------------------------+
module tb_apb_master_arbiter;

  localparam int TO = 4;

  logic        PCLK = 1'b0;
  logic        PRESET = 1'b0;
  logic        q_valid [2];
  logic        q_write [2];
  logic [31:0] q_addr  [2];
  logic [31:0] q_wdata [2];
  logic        req0_grant, req0_done, req0_err, req1_grant, req1_done, req1_err;
  logic [31:0] req0_rdata, req1_rdata;
  logic        PSEL, PENABLE, PWRITE;
  logic [31:0] PADDR, PWDATA;
  logic [31:0] PRDATA = '0;
  logic        PREADY = 1'b0;
  logic        PSLVERR = 1'b0;

  int n_vec = 0;
  int n_bad = 0;

  always #5 PCLK = ~PCLK;

  apb_master_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(TO)) dut (
    .PCLK(PCLK), .PRESET(PRESET),
    .req0_valid(q_valid[0]), .req0_write(q_write[0]), .req0_addr(q_addr[0]),
    .req0_wdata(q_wdata[0]), .req0_grant(req0_grant), .req0_done(req0_done),
    .req0_rdata(req0_rdata), .req0_err(req0_err),
    .req1_valid(q_valid[1]), .req1_write(q_write[1]), .req1_addr(q_addr[1]),
    .req1_wdata(q_wdata[1]), .req1_grant(req1_grant), .req1_done(req1_done),
    .req1_rdata(req1_rdata), .req1_err(req1_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
    .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  typedef struct {
    int          id;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    bit          slverr;
    bit          exp_err;
    int          exp_acc;
    logic [31:0] exp_rdata;
  } vec_t;

  task automatic step();
    @(posedge PCLK);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic set_req(input int n, input logic v, input logic w,
                         input logic [31:0] a, input logic [31:0] d);
    q_valid[n] = v;
    q_write[n] = w;
    q_addr[n]  = a;
    q_wdata[n] = d;
  endtask

  task automatic do_reset();
    PRESET = 1'b1;
    step();
    step();
    PRESET = 1'b0;
  endtask

  // One isolated transfer from an idle bus, slave inserting v.waits wait states.
  task automatic run_vec(input vec_t v);
    int  acc;
    bit  seen;
    logic [31:0] rd;
    acc  = 0;
    seen = 1'b0;
    set_req(v.id, 1'b1, v.wr, v.addr, v.wdata);
    PREADY = 1'b0;
    step();
    chk("vec_grant", {30'd0, req1_grant, req0_grant}, (v.id != 0) ? 32'd2 : 32'd1);
    chk("vec_setup_bus", {30'd0, PSEL, PENABLE}, 32'd2);
    chk("vec_paddr", PADDR, v.addr);
    chk("vec_pwrite", {31'd0, PWRITE}, {31'd0, v.wr});
    q_valid[v.id] = 1'b0;
    step();
    for (int k = 0; k < 20; k++) begin
      if (req0_done || req1_done) begin
        seen = 1'b1;
        break;
      end
      acc++;
      chk("vec_access_bus", {30'd0, PSEL, PENABLE}, 32'd3);
      chk("vec_pwdata", PWDATA, v.wdata);
      PREADY  = (k == v.waits);
      PRDATA  = v.prdata;
      PSLVERR = v.slverr;
      step();
    end
    PREADY  = 1'b0;
    PSLVERR = 1'b0;
    chk("vec_done_seen", {31'd0, seen}, 32'd1);
    chk("vec_access_cycles", acc, v.exp_acc);
    chk("vec_done", {30'd0, req1_done, req0_done}, (v.id != 0) ? 32'd2 : 32'd1);
    chk("vec_err", {30'd0, req1_err, req0_err}, v.exp_err ? ((v.id != 0) ? 32'd2 : 32'd1) : 32'd0);
    rd = (v.id != 0) ? req1_rdata : req0_rdata;
    chk("vec_rdata", rd, v.exp_rdata);
    chk("vec_done_bus", {30'd0, PSEL, PENABLE}, 32'd0);
    step();
    chk("vec_after_done", {28'd0, PSEL, PENABLE, req1_done, req0_done}, 32'd0);
  endtask

  vec_t tbl [7];
  int   order [4];
  int   n_g;

  // Transaction-level reference model state for the random phase.
  int          g_cyc, d_cyc, m_waits, m_acc;
  bit          m_owner, m_last, m_wr, m_to, m_pend_err, w;
  logic [31:0] m_addr, m_wdata, m_pend_rd;
  logic [31:0] exp_rd [2];
  logic [1:0]  e_grant, e_done, e_err, oh;
  bit          e_psel, e_pen;

  initial begin
    for (int n = 0; n < 2; n++) set_req(n, 1'b0, 1'b0, 32'h0, 32'h0);

    tbl[0] = '{0, 1'b0, 32'h0000_0010, 32'h0,          0, 32'hDEAD_BEEF, 1'b0, 1'b0, 1, 32'hDEAD_BEEF};
    tbl[1] = '{1, 1'b1, 32'h0000_0020, 32'h1234_5678,  3, 32'h9999_9999, 1'b0, 1'b0, 4, 32'h0};
    tbl[2] = '{1, 1'b0, 32'h0000_0030, 32'h0,          1, 32'hCAFE_F00D, 1'b1, 1'b1, 2, 32'hCAFE_F00D};
    tbl[3] = '{0, 1'b1, 32'h0000_0040, 32'h5555_AAAA, TO, 32'h1111_2222, 1'b0, 1'b0, TO + 1, 32'hDEAD_BEEF};
    tbl[4] = '{0, 1'b0, 32'h0000_0050, 32'h0,          9, 32'h1111_1111, 1'b0, 1'b1, TO + 1, 32'hDEAD_BEEF};
    tbl[5] = '{1, 1'b0, 32'h0000_0060, 32'h0,          0, 32'hA5A5_A5A5, 1'b0, 1'b0, 1, 32'hA5A5_A5A5};
    tbl[6] = '{1, 1'b1, 32'h0000_0070, 32'h7777_0000,  2, 32'h3333_3333, 1'b1, 1'b1, 3, 32'hA5A5_A5A5};

    do_reset();
    chk("rst_ctl", {24'd0, PSEL, PENABLE, PWRITE, req0_grant, req1_grant,
                    req0_done, req1_done, req0_err | req1_err}, 32'd0);
    chk("rst_paddr", PADDR, 32'd0);
    chk("rst_pwdata", PWDATA, 32'd0);
    chk("rst_rdata0", req0_rdata, 32'd0);
    chk("rst_rdata1", req1_rdata, 32'd0);

    for (int i = 0; i < 7; i++) run_vec(tbl[i]);

    // Both requesters hammer the bus; grants must alternate starting with req0.
    set_req(0, 1'b1, 1'b0, 32'h0000_0100, 32'h11);
    set_req(1, 1'b1, 1'b0, 32'h0000_0200, 32'h22);
    PREADY = 1'b1;
    PRDATA = 32'h0000_0077;
    do_reset();
    order = '{-1, -1, -1, -1};
    n_g = 0;
    for (int c = 0; c < 40 && n_g < 4; c++) begin
      step();
      chk("cont_onehot", {31'd0, (req0_grant & req1_grant) | (req0_done & req1_done)}, 32'd0);
      if (req0_grant) begin order[n_g] = 0; n_g++; q_valid[0] = 1'b0; end
      else if (req1_grant) begin order[n_g] = 1; n_g++; q_valid[1] = 1'b0; end
      if (req0_done) q_valid[0] = 1'b1;
      if (req1_done) q_valid[1] = 1'b1;
    end
    chk("cont_grants", n_g, 32'd4);
    for (int i = 0; i < 4; i++) chk("cont_order", order[i], i % 2);
    q_valid[0] = 1'b0;
    q_valid[1] = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // Reset lands in the second ACCESS cycle of a req0 read.
    set_req(0, 1'b1, 1'b0, 32'h0000_0080, 32'h0000_ABCD);
    PREADY = 1'b0;
    step();
    chk("mid_grant", {30'd0, req1_grant, req0_grant}, 32'd1);
    q_valid[0] = 1'b0;
    step();
    step();
    chk("mid_access", {30'd0, PSEL, PENABLE}, 32'd3);
    PRESET = 1'b1;
    set_req(0, 1'b1, 1'b0, 32'h0000_0090, 32'h0);
    set_req(1, 1'b1, 1'b0, 32'h0000_00A0, 32'h0);
    step();
    chk("mid_rst_ctl", {24'd0, PSEL, PENABLE, PWRITE, req0_grant, req1_grant,
                        req0_done, req1_done, req0_err | req1_err}, 32'd0);
    chk("mid_rst_paddr", PADDR, 32'd0);
    chk("mid_rst_pwdata", PWDATA, 32'd0);
    chk("mid_rst_rdata0", req0_rdata, 32'd0);
    chk("mid_rst_rdata1", req1_rdata, 32'd0);
    PRESET = 1'b0;
    step();
    chk("mid_first_grant", {28'd0, req1_grant, req0_grant, req1_done, req0_done}, 32'd4);
    q_valid[0] = 1'b0;
    q_valid[1] = 1'b0;
    PREADY = 1'b1;
    for (int i = 0; i < 4; i++) step();

    // Randomised traffic against a transaction-timeline model.
    do_reset();
    q_valid[0] = 1'b0;
    q_valid[1] = 1'b0;
    g_cyc = -100; d_cyc = -100; m_last = 1'b1; m_owner = 1'b0;
    m_wr = 1'b0; m_to = 1'b0; m_addr = '0; m_wdata = '0;
    m_pend_rd = '0; m_pend_err = 1'b0; m_waits = 0; m_acc = 0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      oh = m_owner ? 2'b10 : 2'b01;
      if (cyc == d_cyc && !m_to && !m_wr) exp_rd[m_owner] = m_pend_rd;
      e_grant = (cyc == g_cyc) ? oh : 2'b00;
      e_done  = (cyc == d_cyc) ? oh : 2'b00;
      e_err   = (cyc == d_cyc && (m_to || m_pend_err)) ? oh : 2'b00;
      e_psel  = (cyc >= g_cyc) && (cyc < d_cyc);
      e_pen   = (cyc > g_cyc) && (cyc < d_cyc);
      chk("rnd_ctl", {24'd0, req1_grant, req0_grant, req1_done, req0_done,
                      req1_err, req0_err, PSEL, PENABLE},
          {24'd0, e_grant, e_done, e_err, e_psel, e_pen});
      chk("rnd_paddr", PADDR, m_addr);
      chk("rnd_pwdata", PWDATA, m_wdata);
      chk("rnd_pwrite", {31'd0, PWRITE}, {31'd0, m_wr});
      chk("rnd_rdata0", req0_rdata, exp_rd[0]);
      chk("rnd_rdata1", req1_rdata, exp_rd[1]);

      for (int n = 0; n < 2; n++) begin
        if (cyc == g_cyc && n == int'(m_owner)) q_valid[n] = 1'b0;
        else if (!q_valid[n] && $urandom_range(0, 3) == 0)
          set_req(n, 1'b1, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end

      if (cyc >= d_cyc && (q_valid[0] || q_valid[1])) begin
        w = (q_valid[0] && q_valid[1]) ? !m_last : q_valid[1];
        m_owner = w;
        m_last  = w;
        m_wr    = q_write[w];
        m_addr  = q_addr[w];
        m_wdata = q_wdata[w];
        m_waits = $urandom_range(0, TO + 2);
        m_to    = (m_waits > TO);
        m_acc   = (m_to ? TO : m_waits) + 1;
        g_cyc   = cyc + 1;
        d_cyc   = cyc + 2 + m_acc;
      end

      PRDATA  = $urandom;
      PSLVERR = 1'($urandom_range(0, 1));
      PREADY  = 1'($urandom_range(0, 1));
      if (cyc > g_cyc && cyc < d_cyc) begin
        PREADY = ((cyc - g_cyc - 1) == m_waits);
        if (PREADY) begin
          m_pend_rd  = PRDATA;
          m_pend_err = PSLVERR;
        end
      end
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
